// File: rtl/f2c_dma_writer.sv
// FPGA-to-CPU DMA writer.
// Takes packet flits and per-packet metadata from the F2C FIFOs and writes
// them as Avalon-MM bursts into the CPU packet ring. Bursts are capped at
// MAX_BURST flits and split where the ring wraps. After the data it can write
// an RX descriptor. TX completions are interleaved, and a packet that is ready
// waits behind at most TX_MAX_CONSEC of them.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | arbitrate between a TX completion and the next packet
// HEAD   | first flit of a burst (address/burstcount loaded), or drop a flit
// BODY   | remaining flits of the current burst
// DESC   | write the 64-byte RX descriptor for the finished packet
module f2c_dma_writer #(
    parameter int DATA_W        = 512,
    parameter int RB_AWIDTH     = 16,
    parameter int MAX_BURST     = 8,
    parameter int TX_MAX_CONSEC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sw_reset,
    input  logic [DATA_W-1:0]      pkt_data,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic                   meta_valid,
    output logic                   meta_ready,
    input  logic [15:0]            meta_size,
    input  logic [RB_AWIDTH-1:0]   meta_pkt_tail,
    input  logic [RB_AWIDTH-1:0]   meta_dsc_tail,
    input  logic [63:0]            meta_pkt_addr,
    input  logic [63:0]            meta_dsc_addr,
    input  logic [31:0]            meta_queue_id,
    input  logic                   meta_needs_dsc,
    input  logic                   meta_drop,
    input  logic                   txc_valid,
    output logic                   txc_ready,
    input  logic [63:0]            txc_dsc_addr,
    input  logic [63:0]            txc_xfer_addr,
    input  logic [31:0]            txc_length,
    input  logic [RB_AWIDTH:0]     pkt_rb_size,
    input  logic                   bas_waitrequest,
    output logic [63:0]            bas_address,
    output logic [DATA_W/8-1:0]    bas_byteenable,
    output logic                   bas_write,
    output logic [DATA_W-1:0]      bas_writedata,
    output logic [3:0]             bas_burstcount,
    output logic [31:0]            waitreq_cnt,
    output logic [31:0]            drop_flit_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HEAD = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;
    localparam logic [1:0] S_DESC = 2'd3;

    localparam int CW = $clog2(TX_MAX_CONSEC + 1);
    localparam logic [CW-1:0] CONSEC_MAX = CW'(TX_MAX_CONSEC);

    logic [1:0]            state;
    logic [CW-1:0]         consec;
    logic [63:0]           pkt_addr_q;
    logic [63:0]           dsc_addr_q;
    logic [RB_AWIDTH-1:0]  dsc_tail_q;
    logic [31:0]           queue_id_q;
    logic                  needs_dsc_q;
    logic                  skip_q;
    logic [RB_AWIDTH-1:0]  tail_q;
    logic [15:0]           rem_q;
    logic [3:0]            left_q;

    logic                  srst;
    logic                  advance;
    logic                  take_txc;
    logic                  take_meta;
    logic                  take_flit;
    logic                  last_flit;
    logic [RB_AWIDTH-1:0]  ring_mask;
    logic [RB_AWIDTH-1:0]  tail_next;
    logic [RB_AWIDTH:0]    room;
    logic [3:0]            len;
    logic [DATA_W-1:0]     txc_word;
    logic [DATA_W-1:0]     desc_word;

    assign srst           = rst | sw_reset;
    assign advance        = ~bas_write | ~bas_waitrequest;
    assign bas_byteenable = '1;
    assign last_flit      = (rem_q == 16'd1);
    assign ring_mask      = pkt_rb_size[RB_AWIDTH-1:0] - RB_AWIDTH'(1);
    assign tail_next      = (tail_q + RB_AWIDTH'(1)) & ring_mask;
    assign room           = pkt_rb_size - {1'b0, tail_q};

    // Burst length: bounded by remaining flits, MAX_BURST and room before wrap.
    always_comb begin
        len = 4'(MAX_BURST);
        if (rem_q < 16'(len)) begin
            len = rem_q[3:0];
        end
        if (room < (RB_AWIDTH+1)'(len)) begin
            len = room[3:0];
        end
    end

    // Completion and descriptor beat layouts.
    always_comb begin
        txc_word                   = '0;
        txc_word[127:64]           = txc_xfer_addr;
        txc_word[159:128]          = txc_length;
        desc_word                  = '0;
        desc_word[0]               = 1'b1;
        desc_word[32 +: RB_AWIDTH] = tail_q;
        desc_word[95:64]           = queue_id_q;
    end

    // Pop decisions; arbitration only happens in IDLE, and nothing pops in reset.
    always_comb begin
        take_txc  = (state == S_IDLE) && advance && txc_valid &&
                    (!meta_valid || (consec < CONSEC_MAX));
        take_meta = (state == S_IDLE) && advance && !take_txc && meta_valid && pkt_valid;
        take_flit = ((state == S_HEAD) || (state == S_BODY)) && advance && pkt_valid;
        txc_ready  = take_txc  & ~srst;
        meta_ready = take_meta & ~srst;
        pkt_ready  = take_flit & ~srst;
    end

    // Main sequencer: Avalon master registers, ring tails and counters.
    always_ff @(posedge clk) begin
        if (srst) begin
            state          <= S_IDLE;
            consec         <= '0;
            pkt_addr_q     <= '0;
            dsc_addr_q     <= '0;
            dsc_tail_q     <= '0;
            queue_id_q     <= '0;
            needs_dsc_q    <= 1'b0;
            skip_q         <= 1'b0;
            tail_q         <= '0;
            rem_q          <= '0;
            left_q         <= '0;
            bas_write      <= 1'b0;
            bas_address    <= '0;
            bas_burstcount <= '0;
            bas_writedata  <= '0;
            waitreq_cnt    <= '0;
            drop_flit_cnt  <= '0;
        end else begin
            if (bas_write && bas_waitrequest) begin
                waitreq_cnt <= waitreq_cnt + 32'd1;
            end
            if (advance) begin
                bas_write <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (take_txc) begin
                            bas_write      <= 1'b1;
                            bas_address    <= txc_dsc_addr;
                            bas_burstcount <= 4'd1;
                            bas_writedata  <= txc_word;
                            if (consec != CONSEC_MAX) begin
                                consec <= consec + CW'(1);
                            end
                        end else if (take_meta) begin
                            pkt_addr_q  <= meta_pkt_addr;
                            dsc_addr_q  <= meta_dsc_addr;
                            dsc_tail_q  <= meta_dsc_tail;
                            queue_id_q  <= meta_queue_id;
                            needs_dsc_q <= meta_needs_dsc;
                            skip_q      <= meta_drop || (meta_pkt_addr == 64'd0) ||
                                           (meta_dsc_addr == 64'd0);
                            tail_q      <= meta_pkt_tail;
                            rem_q       <= meta_size;
                            consec      <= '0;
                            state       <= S_HEAD;
                        end
                    end
                    S_HEAD: begin
                        if (pkt_valid) begin
                            rem_q  <= rem_q - 16'd1;
                            tail_q <= tail_next;
                            if (skip_q) begin
                                drop_flit_cnt <= drop_flit_cnt + 32'd1;
                                if (last_flit) begin
                                    state <= S_IDLE;
                                end
                            end else begin
                                bas_write      <= 1'b1;
                                bas_address    <= pkt_addr_q + 64'({tail_q, 6'b0});
                                bas_burstcount <= len;
                                bas_writedata  <= pkt_data;
                                if (len != 4'd1) begin
                                    left_q <= len - 4'd1;
                                    state  <= S_BODY;
                                end else if (last_flit) begin
                                    state <= needs_dsc_q ? S_DESC : S_IDLE;
                                end
                            end
                        end
                    end
                    S_BODY: begin
                        if (pkt_valid) begin
                            bas_write     <= 1'b1;
                            bas_writedata <= pkt_data;
                            rem_q         <= rem_q - 16'd1;
                            tail_q        <= tail_next;
                            left_q        <= left_q - 4'd1;
                            if (left_q == 4'd1) begin
                                if (!last_flit) begin
                                    state <= S_HEAD;
                                end else begin
                                    state <= needs_dsc_q ? S_DESC : S_IDLE;
                                end
                            end
                        end
                    end
                    S_DESC: begin
                        bas_write      <= 1'b1;
                        bas_address    <= dsc_addr_q + 64'({dsc_tail_q, 6'b0});
                        bas_burstcount <= 4'd1;
                        bas_writedata  <= desc_word;
                        state          <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/f2c_dma_writer.md
Name: f2c_dma_writer

Overview:
- Parametrised next-generation FPGA-to-CPU DMA engine.
- Pops packet flits plus per-packet metadata, and issues Avalon-MM burst writes into the CPU packet ring. Each burst is capped by MAX_BURST and split at ring wrap.
- After the packet data it writes a 64-byte RX descriptor. It interleaves TX-completion descriptors with a bounded-starvation arbiter.
- Sits between the F2C packet/metadata FIFOs and the PCIe BAS write port.

Parameters:
- DATA_W, 512, flit and writedata width in bits; multiple of 64.
- RB_AWIDTH, 16, ring index width; ring sizes are powers of two, at most 2^RB_AWIDTH.
- MAX_BURST, 8, maximum flits per burst (1..15).
- TX_MAX_CONSEC, 4, maximum consecutive TX completions served while a packet is waiting.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- sw_reset  in  1  synchronous soft reset; same effect as rst
- pkt_data  in  DATA_W  flit payload
- pkt_valid  in  1  flit valid
- pkt_ready  out  1  flit pop
- meta_valid  in  1  metadata valid
- meta_ready  out  1  metadata pop
- meta_size  in  16  packet length in flits (>=1)
- meta_pkt_tail  in  RB_AWIDTH  packet-ring tail, in flits
- meta_dsc_tail  in  RB_AWIDTH  descriptor-ring tail
- meta_pkt_addr  in  64  packet-ring base
- meta_dsc_addr  in  64  descriptor-ring base
- meta_queue_id  in  32  queue id
- meta_needs_dsc  in  1  write a descriptor after the data
- meta_drop  in  1  consume the packet without writing
- txc_valid  in  1  TX completion valid
- txc_ready  out  1  TX completion pop
- txc_dsc_addr  in  64  completion destination address
- txc_xfer_addr  in  64  completed transfer address
- txc_length  in  32  completed transfer length
- pkt_rb_size  in  RB_AWIDTH+1  packet ring size, in flits
- bas_waitrequest  in  1  Avalon waitrequest
- bas_address  out  64
- bas_byteenable  out  DATA_W/8
- bas_write  out  1
- bas_writedata  out  DATA_W
- bas_burstcount  out  4
- waitreq_cnt  out  32  cycles with write=1 and waitrequest=1
- drop_flit_cnt  out  32  flits consumed without a write

Behaviour:
- Reset (rst or sw_reset):
  - bas_write=0, bas_address=0, bas_burstcount=0.
  - Counters cleared; state IDLE; arbiter consecutive count cleared.
  - Any in-flight burst is abandoned. Upstream FIFOs are cleared by the same reset.
- Avalon rules:
  - While bas_write=1 and bas_waitrequest=1, all bas_* outputs hold and no input is popped.
  - "advance" = !bas_write | !bas_waitrequest.
  - byteenable is always all-ones.
- States: IDLE, HEAD, BODY, DESC.
- IDLE, on advance:
  - If txc_valid and (!meta_valid or consec<TX_MAX_CONSEC): pop the completion and write 1 beat, burstcount=1, address=txc_dsc_addr. writedata: [0]=0, [127:64]=xfer_addr, [159:128]=length, rest 0. consec++.
  - Else if meta_valid and pkt_valid: latch the metadata, pop it (meta_ready=1), clear consec, go to HEAD in the same cycle.
- HEAD, on advance with pkt_valid:
  - Compute len = min(rem, MAX_BURST, pkt_rb_size-tail).
  - Drive address=pkt_addr+64*tail, burstcount=len, writedata=flit; pop the flit.
  - Update tail=(tail+1)&(pkt_rb_size-1) and rem--.
  - If len>1, go to BODY with left=len-1.
  - If len==1 and rem>0, stay in HEAD; otherwise go to DESC or IDLE.
- BODY, on advance with pkt_valid:
  - Pop the flit and write it; address and burstcount are held (don't-care).
  - tail++ (masked), rem--, left--.
  - When left reaches 0: go to HEAD if rem>0, else DESC if needs_dsc, else IDLE.
- If pkt_valid=0 in HEAD or BODY: bas_write=0 for that cycle; state and counters hold.
- Drop or zero address (drop=1, pkt_addr==0 or dsc_addr==0):
  - Flits are popped one per cycle with bas_write=0; drop_flit_cnt increments per flit.
  - No descriptor is written; return to IDLE after the last flit.
- DESC, on advance:
  - Write 1 beat, address=dsc_addr+64*dsc_tail.
  - writedata: [0]=1, [32+:RB_AWIDTH]=final pkt tail, [95:64]=queue_id, rest 0.
  - Go to IDLE.
- Tail wrap: a burst never crosses index pkt_rb_size-1; the next burst starts at 0.
- rem is 16-bit, so sizes up to 65535 flits are supported.
- Simultaneous events:
  - A txc arriving during a packet waits until IDLE.
  - Arbitration is evaluated only in IDLE.

Test Plan:
- size=3, tail=0, pkt_addr=0x1000, dsc_addr=0x2000, needs_dsc=1, no waitrequest -> burst of 3 at 0x1000 with burstcount=3, then descriptor at 0x2000*; tail field=3.
- size=20, MAX_BURST=8, tail=0, ring=64 -> three bursts: burstcount 8 at +0, 8 at +512, 4 at +1024.
- pkt_rb_size=16, tail=14, size=5 -> burst of 2 at +896, then burst of 3 at +0; descriptor tail=3.
- waitrequest high for 5 cycles mid-burst -> outputs stable, no flit popped, waitreq_cnt=5, data order intact.
- 6 txc queued plus a packet waiting, TX_MAX_CONSEC=4 -> 4 completions, then the packet, then the remaining 2 completions; completion writedata[0]=0.
- drop=1, size=4 -> 4 flits popped, bas_write never 1, drop_flit_cnt=4; assert rst mid-burst -> bas_write=0 next cycle, state IDLE.

\* "then descriptor at 0x2000" assumes dsc_tail=0.
